// File: rtl/divider2.sv
// -----------------------------------------------------------------------------
// divider2 -- 16-bit by 8-bit unsigned restoring divider, one quotient bit per
// clock, MSB first.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   request pulse; accepted only in IDLE or DONE
//   A            in  16   dividend, captured on the accepted start edge
//   B            in   8   divisor, captured on the accepted start edge
//   Quotient     out 16   registered quotient (updated only on completion)
//   Remainder    out  8   registered remainder (updated only on completion)
//   ready        out  1   high exactly while in DONE
//   busy         out  1   high exactly while in CALC
//   div_by_zero  out  1   high with ready when the accepted divisor was 0
//   dbg_state_o  out  2   current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: start is a request qualified only by the FSM being in IDLE or
// DONE at the sampling edge; there is no back-pressure, so a start seen in
// CALC is simply dropped. ready/busy are decoded straight from the state
// register so they are glitch-free and change only on clock edges or reset.
// -----------------------------------------------------------------------------
module divider2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    output logic [15:0] Quotient,
    output logic [7:0]  Remainder,
    output logic        ready,
    output logic        busy,
    output logic        div_by_zero,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;     // iteration index 0..15
    logic [15:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [7:0]  rem_q, rem_d;     // partial remainder, always < divisor
    logic [7:0]  dvs_q, dvs_d;     // captured divisor
    logic        pend_q, pend_d;   // divide-by-zero result due on the next edge
    logic [15:0] quo_q, quo_d;
    logic [7:0]  rmd_q, rmd_d;
    logic        dbz_q, dbz_d;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    logic [8:0]  trial;
    logic [7:0]  sub;
    logic        qbit;
    logic [7:0]  rem_next;
    logic [15:0] dvd_next;

    assign trial    = {rem_q, dvd_q[15]};
    // When trial >= divisor the difference is < divisor <= 255, so the low
    // 8 bits of the modulo-256 subtraction are exact.
    assign sub      = trial[7:0] - dvs_q;
    assign qbit     = (trial >= {1'b0, dvs_q});
    assign rem_next = qbit ? sub : trial[7:0];
    assign dvd_next = {dvd_q[14:0], qbit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        pend_d  = pend_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (pend_q) begin
                    // Second edge of a divide-by-zero request: publish the
                    // saturated result. Any start on this edge is ignored.
                    pend_d  = 1'b0;
                    state_d = S_DONE;
                    quo_d   = 16'hFFFF;
                    rmd_d   = 8'h00;
                    dbz_d   = 1'b1;
                end else if (start) begin
                    dvd_d = A;
                    dvs_d = B;
                    rem_d = 8'h00;
                    cnt_d = 4'd0;
                    dbz_d = 1'b0;
                    if (B == 8'h00) begin
                        // Skip CALC; park in IDLE for one edge so ready drops.
                        pend_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                dvd_d = dvd_next;
                rem_d = rem_next;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_DONE;
                    quo_d   = dvd_next;
                    rmd_d   = rem_next;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            dvd_q   <= 16'h0000;
            rem_q   <= 8'h00;
            dvs_q   <= 8'h00;
            pend_q  <= 1'b0;
            quo_q   <= 16'h0000;
            rmd_q   <= 8'h00;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            pend_q  <= pend_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Quotient    = quo_q;
    assign Remainder   = rmd_q;
    assign ready       = (state_q == S_DONE);
    assign busy        = (state_q == S_CALC);
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_divider2.sv
module tb_divider2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [7:0]  B;
  logic [15:0] Quotient;
  logic [7:0]  Remainder;
  logic        ready;
  logic        busy;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  divider2 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .ready       (ready),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [24:0] exp_q[$];        // {quotient, remainder, div_by_zero}
  logic [15:0] prev_q = 16'h0;  // last published result, held during work
  logic [7:0]  prev_r = 8'h0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer division.
  function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b);
    int qi, ri;
    if (b == 8'd0) return {16'hFFFF, 8'h00, 1'b1};
    qi = int'(a) / int'(b);
    ri = int'(a) % int'(b);
    return {qi[15:0], ri[7:0], 1'b0};
  endfunction

  // ---------------- driver ----------------
  // Entered shortly after a rising edge. Issues one operation, checks the
  // in-progress outputs every cycle, then latency and result. If inject_at > 0
  // a foreign start (9/3) is pulsed into the edge after that many cycles.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int inject_at);
    int lat;
    int exp_lat;
    logic [24:0] e;
    exp_q.push_back(model(a, b));
    exp_lat = (b == 8'd0) ? 1 : 16;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'($urandom); B = 8'($urandom);
    lat = 0;
    while (!ready && lat < 40) begin
      chk("busy_during", {31'd0, busy}, {31'd0, (b != 8'd0)});
      chk("dbz_during", {31'd0, div_by_zero}, 32'd0);
      chk("quo_held", {16'd0, Quotient}, {16'd0, prev_q});
      chk("rem_held", {24'd0, Remainder}, {24'd0, prev_r});
      @(posedge clk); #1;
      lat++;
      if (inject_at > 0 && lat == inject_at) begin
        A = 16'd9; B = 8'd3; start = 1'b1;
      end else if (inject_at > 0 && lat == inject_at + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", lat, exp_lat);
    e = exp_q.pop_front();
    chk("quotient", {16'd0, Quotient}, {16'd0, e[24:9]});
    chk("remainder", {24'd0, Remainder}, {24'd0, e[8:1]});
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[0]});
    chk("busy_done", {31'd0, busy}, 32'd0);
    prev_q = e[24:9];
    prev_r = e[8:1];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q"}, {16'd0, Quotient}, 32'd0);
    chk({tag, "_r"}, {24'd0, Remainder}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;

    vecs[0] = '{a: 16'd1000,  b: 8'd7,   q: 16'd142,   r: 8'd6, dbz: 1'b0};
    vecs[1] = '{a: 16'd65535, b: 8'd255, q: 16'd257,   r: 8'd0, dbz: 1'b0};
    vecs[2] = '{a: 16'd5,     b: 8'd200, q: 16'd0,     r: 8'd5, dbz: 1'b0};
    vecs[3] = '{a: 16'd1234,  b: 8'd0,   q: 16'hFFFF,  r: 8'd0, dbz: 1'b1};
    vecs[4] = '{a: 16'd50000, b: 8'd13,  q: 16'd3846,  r: 8'd2, dbz: 1'b0};

    rst_n = 1'b0; start = 1'b0; A = 16'd0; B = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("idle");

    // Table vectors: bench constants compared against the DUT and the model.
    for (int i = 0; i < 5; i++) begin
      chk("model_vs_table", {7'd0, model(vecs[i].a, vecs[i].b)},
          {7'd0, vecs[i].q, vecs[i].r, vecs[i].dbz});
      run_op(vecs[i].a, vecs[i].b, 0);
    end

    // DONE holds indefinitely without start.
    repeat (5) @(posedge clk);
    #1;
    chk("hold_ready", {31'd0, ready}, 32'd1);
    chk("hold_q", {16'd0, Quotient}, {16'd0, prev_q});
    chk("hold_r", {24'd0, Remainder}, {24'd0, prev_r});

    // Start pulse during CALC is ignored.
    run_op(16'd1000, 8'd7, 5);
    chk("inject_q", {16'd0, Quotient}, 32'd142);
    chk("inject_r", {24'd0, Remainder}, 32'd6);

    // Divide by zero followed immediately by a normal op (dbz must clear).
    run_op(16'd1234, 8'd0, 0);
    run_op(16'd300, 8'd10, 0);

    // Reset in the middle of CALC aborts with no partial result.
    A = 16'd50000; B = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk_all_zero("abort");
    prev_q = 16'd0; prev_r = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("after_abort");
    run_op(16'd50000, 8'd13, 0);

    // Random back-to-back operations issued straight from DONE.
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_op(ra, rb, 0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
